// File: rtl/mux_4_pkg.sv
// Shared definitions for the mux_4 slice.
//   SEL_R1..SEL_R4 : select codes {s1,s0} that choose operand r1..r4
//   DATA_W         : default operand / result width
package mux_pkg;

    localparam logic [1:0] SEL_R1 = 2'b00;
    localparam logic [1:0] SEL_R2 = 2'b01;
    localparam logic [1:0] SEL_R3 = 2'b10;
    localparam logic [1:0] SEL_R4 = 2'b11;

    localparam int DATA_W = 8;

endpackage

// File: rtl/mux_4_if.sv
// Bus bundle between a mux_4 instance and whatever drives its operands.
//   r1..r4  : operand buses (WIDTH bits)
//   s0, s1  : select LSB / MSB
//   en      : capture enable
//   out     : selected operand
//   sel_q   : select captured with out, as {s1,s0}
//   sel_chg : one-cycle pulse when the captured select changes
// master = operand source, slave = the multiplexer.
interface mux_4_if
    import mux_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    logic [WIDTH-1:0] r3;
    logic [WIDTH-1:0] r4;
    logic             s0;
    logic             s1;
    logic             en;
    logic [WIDTH-1:0] out;
    logic [1:0]       sel_q;
    logic             sel_chg;

    modport master (
        output r1, r2, r3, r4, s0, s1, en,
        input  out, sel_q, sel_chg
    );

    modport slave (
        input  r1, r2, r3, r4, s0, s1, en,
        output out, sel_q, sel_chg
    );
endinterface

// File: rtl/mux_4_mux_2.sv
// 2:1 multiplexer, the leaf cell of the mux_4 select tree.
//   a : chosen when s = 0
//   b : chosen when s = 1
//   s : select
//   y : result
module mux_2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mux_4.sv
// 4-to-1 datapath multiplexer with optional output register.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux_4_if slave port (operands, selects, enable, out, sel_q, sel_chg)
// REGISTERED=1 gives a reset-defined registered out with one edge of latency;
// REGISTERED=0 makes out a pure combinational decode. sel_q / sel_chg are
// registered in both builds.
module mux_4
    import mux_pkg::*;
#(
    parameter int WIDTH      = DATA_W,
    parameter bit REGISTERED = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_4_if.slave     bus
);

    logic [WIDTH-1:0] lvl0_lo_s;
    logic [WIDTH-1:0] lvl0_hi_s;
    logic [WIDTH-1:0] mux_s;
    logic [1:0]       sel_s;
    logic [1:0]       sel_q_r;
    logic             sel_chg_r;

    assign sel_s = {bus.s1, bus.s0};

    // First tree level splits on s0: (r1,r2) and (r3,r4).
    mux_2 #(.WIDTH(WIDTH)) u_lvl0_lo (
        .a (bus.r1),
        .b (bus.r2),
        .s (bus.s0),
        .y (lvl0_lo_s)
    );

    mux_2 #(.WIDTH(WIDTH)) u_lvl0_hi (
        .a (bus.r3),
        .b (bus.r4),
        .s (bus.s0),
        .y (lvl0_hi_s)
    );

    // Second level picks the half with s1, completing a full decode.
    mux_2 #(.WIDTH(WIDTH)) u_lvl1 (
        .a (lvl0_lo_s),
        .b (lvl0_hi_s),
        .s (bus.s1),
        .y (mux_s)
    );

    // Captured select and change pulse; the pulse is compared against the
    // previously captured select, so the first capture after reset compares to SEL_R1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q_r   <= SEL_R1;
            sel_chg_r <= 1'b0;
        end else if (bus.en) begin
            sel_q_r   <= sel_s;
            sel_chg_r <= (sel_s != sel_q_r);
        end else begin
            sel_q_r   <= sel_q_r;
            sel_chg_r <= 1'b0;
        end
    end

    assign bus.sel_q   = sel_q_r;
    assign bus.sel_chg = sel_chg_r;

    generate
        if (REGISTERED) begin : g_out_reg
            logic [WIDTH-1:0] out_r;

            // Output register: captures the decoded operand when enabled.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_r <= {WIDTH{1'b0}};
                end else if (bus.en) begin
                    out_r <= mux_s;
                end else begin
                    out_r <= out_r;
                end
            end

            assign bus.out = out_r;
        end else begin : g_out_comb
            // Zero-latency build: out is the raw decode, independent of en/rst_n.
            assign bus.out = mux_s;
        end
    endgenerate

endmodule

// File: tb/tb_mux_4.sv
// Directed self-checking bench for mux_4: a registered instance and a
// combinational instance (REGISTERED=0) share the same operand/select stimulus.
module tb_mux_4;
    import mux_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    mux_4_if #(.WIDTH(8)) bus_reg ();
    mux_4_if #(.WIDTH(8)) bus_cmb ();

    assign bus_cmb.r1 = bus_reg.r1;
    assign bus_cmb.r2 = bus_reg.r2;
    assign bus_cmb.r3 = bus_reg.r3;
    assign bus_cmb.r4 = bus_reg.r4;
    assign bus_cmb.s0 = bus_reg.s0;
    assign bus_cmb.s1 = bus_reg.s1;
    assign bus_cmb.en = bus_reg.en;

    mux_4 #(.WIDTH(8), .REGISTERED(1'b1)) u_dut_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_reg)
    );

    mux_4 #(.WIDTH(8), .REGISTERED(1'b0)) u_dut_cmb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_cmb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic [1:0] sel);
        bus_reg.s1 = sel[1];
        bus_reg.s0 = sel[0];
    endtask

    task automatic check_reg(input string tag, input logic [7:0] out_e,
                             input logic [1:0] selq_e, input logic chg_e);
        check({tag, ".out"},     {24'd0, bus_reg.out},     {24'd0, out_e});
        check({tag, ".sel_q"},   {30'd0, bus_reg.sel_q},   {30'd0, selq_e});
        check({tag, ".sel_chg"}, {31'd0, bus_reg.sel_chg}, {31'd0, chg_e});
    endtask

    logic [1:0] sweep_sel [4];
    logic [7:0] sweep_out [4];

    initial begin
        tests = 0;
        fails = 0;
        sweep_sel[0] = 2'b00; sweep_out[0] = 8'h00;
        sweep_sel[1] = 2'b10; sweep_out[1] = 8'hFF;
        sweep_sel[2] = 2'b11; sweep_out[2] = 8'h55;
        sweep_sel[3] = 2'b01; sweep_out[3] = 8'hAA;

        rst_n      = 1'b0;
        bus_reg.en = 1'b0;
        bus_reg.r1 = 8'h00;
        bus_reg.r2 = 8'hAA;
        bus_reg.r3 = 8'hFF;
        bus_reg.r4 = 8'h55;
        set_sel(2'b00);
        tick();
        tick();
        check_reg("por", 8'h00, 2'b00, 1'b0);
        #3 rst_n = 1'b1;

        // Load out=FF, then assert reset mid-cycle and check without a clock edge.
        tick();
        bus_reg.en = 1'b1;
        set_sel(2'b10);
        tick();
        check_reg("preload", 8'hFF, 2'b10, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_reg("async_rst", 8'h00, 2'b00, 1'b0);
        check("rst_cmb_out", {24'd0, bus_cmb.out}, 32'h0000_00FF);
        tick();
        check_reg("rst_hold", 8'h00, 2'b00, 1'b0);
        set_sel(2'b00);
        #3 rst_n = 1'b1;

        // Select sweep 00 -> 10 -> 11 -> 01, five cycles each.
        for (int i = 0; i < 4; i++) begin
            set_sel(sweep_sel[i]);
            #1;
            check("sweep_cmb_out", {24'd0, bus_cmb.out}, {24'd0, sweep_out[i]});
            if (i > 0) begin
                check("sweep_latency", {24'd0, bus_reg.out}, {24'd0, sweep_out[i-1]});
            end
            tick();
            check_reg("sweep_edge", sweep_out[i], sweep_sel[i], (i > 0) ? 1'b1 : 1'b0);
            for (int c = 1; c < 5; c++) begin
                tick();
                check_reg("sweep_hold", sweep_out[i], sweep_sel[i], 1'b0);
            end
        end

        // Enable hold.
        set_sel(2'b10);
        tick();
        check_reg("en_pre", 8'hFF, 2'b10, 1'b1);
        bus_reg.en = 1'b0;
        set_sel(2'b11);
        bus_reg.r3 = 8'h12;
        tick();
        check_reg("en_low0", 8'hFF, 2'b10, 1'b0);
        tick();
        check_reg("en_low1", 8'hFF, 2'b10, 1'b0);
        bus_reg.en = 1'b1;
        tick();
        check_reg("en_rise", 8'h55, 2'b11, 1'b1);
        bus_reg.r3 = 8'hFF;

        // Data tracking on the selected operand; unselected operands ignored.
        set_sel(2'b01);
        tick();
        check_reg("trk_sel", 8'hAA, 2'b01, 1'b1);
        bus_reg.r2 = 8'h3C;
        tick();
        check_reg("trk_data", 8'h3C, 2'b01, 1'b0);
        bus_reg.r1 = 8'h11;
        bus_reg.r3 = 8'h22;
        bus_reg.r4 = 8'h77;
        tick();
        check_reg("trk_unsel", 8'h3C, 2'b01, 1'b0);
        bus_reg.r4 = 8'h55;
        tick();

        // Simultaneous select and data change.
        set_sel(2'b11);
        bus_reg.r4 = 8'hC3;
        tick();
        check_reg("simul", 8'hC3, 2'b11, 1'b1);

        // Reset mid-operation, then release with a non-zero select.
        #2 rst_n = 1'b0;
        #1;
        check_reg("rst_mid", 8'h00, 2'b00, 1'b0);
        #3 rst_n = 1'b1;
        tick();
        check_reg("rst_release", 8'hC3, 2'b11, 1'b1);
        tick();
        check_reg("rst_release_hold", 8'hC3, 2'b11, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
